// File: rtl/master_pkg.sv
// Shared definitions for the burst source and its receiver-side benches:
// FSM state encoding and default widths/step.
package master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int GAP_W  = 4;
    localparam int STEP   = 1;

endpackage

// File: rtl/master_burst_src.sv
// Burst source: on start, emits len words seed, seed+STEP, ... over valid/ready,
// with an optional fixed idle gap between beats.
module master_burst_src
    import master_pkg::*;
#(
    parameter int DATA_W_P = master_pkg::DATA_W,
    parameter int LEN_W_P  = master_pkg::LEN_W,
    parameter int GAP_W_P  = master_pkg::GAP_W,
    parameter int STEP_P   = master_pkg::STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W_P-1:0]  len,
    input  logic [DATA_W_P-1:0] seed,
    input  logic [GAP_W_P-1:0]  gap,
    output logic [DATA_W_P-1:0] data,
    output logic                valid,
    input  logic                ready,
    output logic                busy,
    output logic                done,
    output logic [LEN_W_P-1:0]  beat_cnt
);

    state_t               state, state_next;
    logic [LEN_W_P-1:0]   remaining;
    logic [GAP_W_P-1:0]   gap_lat;
    logic [GAP_W_P-1:0]   gap_cnt;
    logic                 last_beat;

    assign last_beat = (remaining == LEN_W_P'(1));

    // valid/busy decode only the state register, so they never see ready or start.
    assign valid = (state == SEND);
    assign busy  = (state != IDLE);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (start && (len != '0)) state_next = SEND;
            SEND: begin
                if (ready) begin
                    if (last_beat)           state_next = IDLE;
                    else if (gap_lat != '0)  state_next = GAP;
                    else                     state_next = SEND;
                end
            end
            GAP:  if (gap_cnt == GAP_W_P'(1)) state_next = SEND;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data      <= '0;
            remaining <= '0;
            gap_lat   <= '0;
            gap_cnt   <= '0;
            done      <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        beat_cnt <= '0;
                        if (len != '0) begin
                            data      <= seed;
                            remaining <= len;
                            gap_lat   <= gap;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (ready) begin
                        data      <= data + DATA_W_P'(STEP_P);
                        remaining <= remaining - LEN_W_P'(1);
                        beat_cnt  <= beat_cnt + LEN_W_P'(1);
                        gap_cnt   <= gap_lat;
                        if (last_beat) done <= 1'b1;
                    end
                end
                GAP: gap_cnt <= gap_cnt - GAP_W_P'(1);
                default: ;
            endcase
        end
    end

endmodule
